// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 active-low keypad matrix: key-code type,
// FSM state enum, idle line level, and the key-to-(row,col) map. The map is
// a plain combinational function so scanner-side decode checks can reuse it.
// ---------------------------------------------------------------------------
package keypad_pkg;

   typedef logic [3:0] key_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BOUNCE = 2'd1,
      ST_HOLD   = 2'd2,
      ST_GAP    = 2'd3
   } state_e;

   // Released matrix lines float high through the pull-ups.
   localparam logic [3:0] LINE_IDLE = 4'b1111;

   // Position 3 corresponds to bit 3 of keypadRow / keypadCol.
   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
   } key_pos_t;

   function automatic key_pos_t key_pos(input key_t k);
      key_pos_t p;
      case (k)
         4'hF: p = '{row: 2'd3, col: 2'd3};
         4'hE: p = '{row: 2'd3, col: 2'd2};
         4'hD: p = '{row: 2'd3, col: 2'd1};
         4'hC: p = '{row: 2'd3, col: 2'd0};
         4'hB: p = '{row: 2'd2, col: 2'd3};
         4'h3: p = '{row: 2'd2, col: 2'd2};
         4'h6: p = '{row: 2'd2, col: 2'd1};
         4'h9: p = '{row: 2'd2, col: 2'd0};
         4'hA: p = '{row: 2'd1, col: 2'd3};
         4'h2: p = '{row: 2'd1, col: 2'd2};
         4'h5: p = '{row: 2'd1, col: 2'd1};
         4'h8: p = '{row: 2'd1, col: 2'd0};
         4'h0: p = '{row: 2'd0, col: 2'd3};
         4'h1: p = '{row: 2'd0, col: 2'd2};
         4'h4: p = '{row: 2'd0, col: 2'd1};
         default: p = '{row: 2'd0, col: 2'd0}; // key 7
      endcase
      return p;
   endfunction

   // A closed contact shorts its row to its column: the column is pulled low
   // only while that key's row strobe is low. Other rows being low as well
   // changes nothing because a single key touches a single row.
   function automatic logic [3:0] matrix_cols(input key_t       k,
                                              input logic       closed,
                                              input logic [3:0] rows);
      logic [3:0] cols;
      key_pos_t   p;
      cols = LINE_IDLE;
      p    = key_pos(k);
      if (closed && !rows[p.row]) begin
         cols[p.col] = 1'b0;
      end
      return cols;
   endfunction

endpackage

// File: rtl/keypad_matrix_model.sv
// ---------------------------------------------------------------------------
// keypad_matrix_model
// Stands in for a physical 4x4 active-low keypad. A requester asks for a key
// press over a valid/ready port; the model closes the contact (with optional
// bounce), holds it, releases it for a gap, then returns to idle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   keypadRow[3:0]  row strobes from the scanner, active low
//   keypadCol[3:0]  column lines back to the scanner, active low, idle 1111
//   cmd_valid       press request valid
//   cmd_ready       model idle and able to accept a request
//   cmd_key[3:0]    key code to press
//   cmd_hold        stable-press duration in cycles (0 behaves as 1)
//   pressed         key contact currently closed (registered)
//   busy            command in progress
//   done            one-cycle pulse on the first idle cycle after a command
//   dbg_state_o     current FSM state for observation
//
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high; cmd_key/cmd_hold are captured on that edge.
// cmd_valid seen while not ready is ignored (not queued); the requester keeps
// it asserted until ready.
// ---------------------------------------------------------------------------
module keypad_matrix_model
   import keypad_pkg::*;
#(
   parameter int HOLD_W        = 16,
   parameter int BOUNCE_CYCLES = 0,
   parameter int GAP_CYCLES    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        keypadRow,
   output logic [3:0]        keypadCol,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_key,
   input  logic [HOLD_W-1:0] cmd_hold,
   output logic              pressed,
   output logic              busy,
   output logic              done,
   output state_e            dbg_state_o
);

   // The phase counter counts down to zero, so each reload is "length - 1".
   localparam logic [HOLD_W-1:0] BOUNCE_LAST =
      HOLD_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
   localparam logic [HOLD_W-1:0] GAP_LAST =
      HOLD_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_e            state_q;
   logic [HOLD_W-1:0] cnt_q;
   logic [HOLD_W-1:0] hold_q;
   key_t              key_q;
   logic              pressed_q;
   logic              done_q;

   // A zero hold still produces a one-cycle press.
   function automatic logic [HOLD_W-1:0] hold_last(input logic [HOLD_W-1:0] h);
      return (h == '0) ? '0 : h - 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hold_q    <= '0;
         key_q     <= '0;
         pressed_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               pressed_q <= 1'b0;
               if (cmd_valid) begin
                  key_q     <= cmd_key;
                  hold_q    <= cmd_hold;
                  // First bounce cycle (index 0) and first hold cycle are both closed.
                  pressed_q <= 1'b1;
                  if (BOUNCE_CYCLES > 0) begin
                     state_q <= ST_BOUNCE;
                     cnt_q   <= BOUNCE_LAST;
                  end else begin
                     state_q <= ST_HOLD;
                     cnt_q   <= hold_last(cmd_hold);
                  end
               end
            end
            ST_BOUNCE: begin
               if (cnt_q == '0) begin
                  state_q   <= ST_HOLD;
                  cnt_q     <= hold_last(hold_q);
                  pressed_q <= 1'b1;
               end else begin
                  cnt_q     <= cnt_q - 1'b1;
                  // Contact alternates each cycle: closed on even indices.
                  pressed_q <= ~pressed_q;
               end
            end
            ST_HOLD: begin
               if (cnt_q == '0) begin
                  pressed_q <= 1'b0;
                  if (GAP_CYCLES > 0) begin
                     state_q <= ST_GAP;
                     cnt_q   <= GAP_LAST;
                  end else begin
                     state_q <= ST_IDLE;
                     done_q  <= 1'b1;
                  end
               end else begin
                  cnt_q     <= cnt_q - 1'b1;
                  pressed_q <= 1'b1;
               end
            end
            ST_GAP: begin
               pressed_q <= 1'b0;
               if (cnt_q == '0) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               pressed_q <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready   = (state_q == ST_IDLE) && !rst;
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign pressed     = pressed_q;
   assign dbg_state_o = state_q;

   // Zero-latency path from the row strobes, as real wiring would have.
   assign keypadCol = matrix_cols(key_q, pressed_q, keypadRow);

endmodule
